cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl_pkg.sv | 53 +++++
 rtl/cp0_ctrl_timer.sv | 74 +++++++
 rtl/cp0_ctrl.sv | 140 ++++++++++++++
 tb/tb_cp0_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cp0_ctrl_pkg
// Shared definitions for the coprocessor-0 control block: register numbers,
// exception codes, reset constants and Status/Cause field positions.
// ---------------------------------------------------------------------------
package cp0_ctrl_pkg;

   // Architectural register width; only 32 is supported.
   localparam int CP0_W = 32;

   // mtc0/mfc0 register numbers.
   typedef enum logic [4:0] {
      CP0_BADVADDR = 5'd8,
      CP0_COUNT    = 5'd9,
      CP0_COMPARE  = 5'd11,
      CP0_STATUS   = 5'd12,
      CP0_CAUSE    = 5'd13,
      CP0_EPC      = 5'd14,
      CP0_PRID     = 5'd15,
      CP0_CONFIG   = 5'd16
   } cp0_reg_e;

   // Exception codes that need special handling.
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   // Reset values.
   localparam logic [CP0_W-1:0] STATUS_RST = 32'h1000_0000;
   localparam logic [CP0_W-1:0] CONFIG_RST = 32'h0000_8000;

   // Status field positions.
   localparam int STATUS_IE    = 0;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IM_LO = 8;

   // Cause field positions.
   localparam int CAUSE_BD      = 31;
   localparam int CAUSE_IV      = 23;
   localparam int CAUSE_WP      = 22;
   localparam int CAUSE_IP_LO   = 8;
   localparam int CAUSE_HWIP_LO = 10;
   localparam int CAUSE_EXC_LO  = 2;

   // Cause bits that software may write: IV, WP and the two software IP bits.
   localparam logic [CP0_W-1:0] CAUSE_WMASK = 32'h00C0_0300;

   // Address-error exceptions are the only ones that capture BadVAddr.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_ctrl_timer.sv
// ---------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer with a sticky timer interrupt.
//   clk, rst      : clock, synchronous active-high reset
//   cnt_we_i      : mtc0 write to Count (wins over increment, restarts divider)
//   cmp_we_i      : mtc0 write to Compare (clears the timer interrupt)
//   wdata_i       : mtc0 write data
//   count_o       : current Count
//   compare_o     : current Compare
//   timer_int_o   : sticky timer interrupt
// ---------------------------------------------------------------------------
module cp0_timer
   import cp0_ctrl_pkg::*;
#(
   parameter int CNT_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_we_i,
   input  logic             cmp_we_i,
   input  logic [CP0_W-1:0] wdata_i,
   output logic [CP0_W-1:0] count_o,
   output logic [CP0_W-1:0] compare_o,
   output logic             timer_int_o
);

   logic [CP0_W-1:0] count_q, count_d;
   logic [CP0_W-1:0] compare_q, compare_d;
   logic             phase_q, phase_d;
   logic             timer_q, timer_d;
   logic             tick;
   logic             match;

   always_comb begin
      // NOTE: every variable gets a default first so always_comb cannot infer a latch.
      tick      = (CNT_DIV == 1) ? 1'b1 : phase_q;
      phase_d   = (CNT_DIV == 2) ? ~phase_q : 1'b0;
      count_d   = tick ? count_q + 1'b1 : count_q;
      compare_d = compare_q;
      match     = (count_q == compare_q) && (compare_q != '0);

      if (cnt_we_i) begin
         count_d = wdata_i;
         phase_d = 1'b0;
      end

      if (cmp_we_i) begin
         compare_d = wdata_i;
      end

      // Sticky once set; a Compare write clears it even in the match cycle.
      timer_d = (timer_q | match) & ~cmp_we_i;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         count_q   <= '0;
         compare_q <= '0;
         phase_q   <= 1'b0;
         timer_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         phase_q   <= phase_d;
         timer_q   <= timer_d;
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_ctrl
// Coprocessor-0 control: Status/Cause/EPC/BadVAddr state, mtc0/mfc0 access,
// exception and eret commit, interrupt request generation.
//   clk, rst            : clock, synchronous active-high reset
//   int_i               : external interrupt levels -> Cause.IP[10 +: NUM_HW_INT]
//   we_i/waddr_i/wdata_i: mtc0 write port
//   raddr_i/rdata_o     : mfc0 read port (combinational, no write bypass)
//   exc_*_i             : exception commit (code, PC, delay slot, bad address)
//   eret_i              : eret commit
//   int_req_o           : interrupt request to the pipeline
//   timer_int_o         : sticky timer interrupt
//   status_o/cause_o/epc_o : current register values
// ---------------------------------------------------------------------------
module cp0_ctrl
   import cp0_ctrl_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                NUM_HW_INT = 6,
   parameter int                TIMER_LINE = 5,
   parameter int                CNT_DIV    = 1,
   parameter logic [DATA_W-1:0] PRID_VAL   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_HW_INT-1:0] int_i,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [4:0]            raddr_i,
   output logic [DATA_W-1:0]     rdata_o,
   input  logic                  exc_valid_i,
   input  logic [4:0]            exc_code_i,
   input  logic [DATA_W-1:0]     exc_pc_i,
   input  logic                  exc_bd_i,
   input  logic [DATA_W-1:0]     exc_badvaddr_i,
   input  logic                  eret_i,
   output logic                  int_req_o,
   output logic                  timer_int_o,
   output logic [DATA_W-1:0]     status_o,
   output logic [DATA_W-1:0]     cause_o,
   output logic [DATA_W-1:0]     epc_o
);

   localparam logic [5:0] TIMER_MASK = 6'(1) << TIMER_LINE;

   logic [DATA_W-1:0] status_q, status_d;
   logic [DATA_W-1:0] cause_q, cause_d;
   logic [DATA_W-1:0] epc_q, epc_d;
   logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
   logic [DATA_W-1:0] count, compare;
   logic              timer_int;
   logic [5:0]        hw_ip;
   logic              exl;
   logic              wr_status, wr_cause, wr_epc;

   assign exl       = status_q[STATUS_EXL];
   assign wr_status = we_i && (waddr_i == CP0_STATUS);
   assign wr_cause  = we_i && (waddr_i == CP0_CAUSE);
   assign wr_epc    = we_i && (waddr_i == CP0_EPC);

   cp0_timer #(
      .CNT_DIV (CNT_DIV)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .cnt_we_i    (we_i && (waddr_i == CP0_COUNT)),
      .cmp_we_i    (we_i && (waddr_i == CP0_COMPARE)),
      .wdata_i     (wdata_i),
      .count_o     (count),
      .compare_o   (compare),
      .timer_int_o (timer_int)
   );

   always_comb begin
      // Hardware IP bits: zero-extended int_i, timer ORed onto its line.
      hw_ip = 6'(int_i) | (timer_int ? TIMER_MASK : 6'b0);

      // Assignment order encodes priority: exception > eret > mtc0.
      status_d = status_q;
      if (wr_status) status_d = wdata_i;
      if (eret_i) status_d[STATUS_EXL] = 1'b0;
      if (exc_valid_i) status_d[STATUS_EXL] = 1'b1;

      cause_d = cause_q;
      if (wr_cause) cause_d = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
      cause_d[CAUSE_HWIP_LO +: 6] = hw_ip;
      if (exc_valid_i) begin
         cause_d[CAUSE_EXC_LO +: 5] = exc_code_i;
         // A nested exception keeps the original BD/EPC of the outer one.
         if (!exl) cause_d[CAUSE_BD] = exc_bd_i;
      end

      epc_d = epc_q;
      if (wr_epc) epc_d = wdata_i;
      if (exc_valid_i && !exl) epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;

      badvaddr_d = badvaddr_q;
      if (exc_valid_i && is_addr_exc(exc_code_i)) badvaddr_d = exc_badvaddr_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q   <= STATUS_RST;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   // Read mux works on current register state; writes land next cycle.
   always_comb begin
      rdata_o = '0;
      case (raddr_i)
         CP0_BADVADDR: rdata_o = badvaddr_q;
         CP0_COUNT:    rdata_o = count;
         CP0_COMPARE:  rdata_o = compare;
         CP0_STATUS:   rdata_o = status_q;
         CP0_CAUSE:    rdata_o = cause_q;
         CP0_EPC:      rdata_o = epc_q;
         CP0_PRID:     rdata_o = PRID_VAL;
         CP0_CONFIG:   rdata_o = CONFIG_RST;
         default:      rdata_o = '0;
      endcase
   end

   assign int_req_o = (|(cause_q[CAUSE_IP_LO +: 8] & status_q[STATUS_IM_LO +: 8]))
                      & status_q[STATUS_IE] & ~exl;

   assign timer_int_o = timer_int;
   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

   localparam logic [31:0] PRID = 32'h0001_9300;

   localparam logic [4:0] R_BVA = 5'd8;
   localparam logic [4:0] R_CNT = 5'd9;
   localparam logic [4:0] R_CMP = 5'd11;
   localparam logic [4:0] R_STS = 5'd12;
   localparam logic [4:0] R_CAU = 5'd13;
   localparam logic [4:0] R_EPC = 5'd14;
   localparam logic [4:0] R_PRI = 5'd15;
   localparam logic [4:0] R_CFG = 5'd16;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  int_i;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic [31:0] exc_badvaddr;
   logic        eret;

   logic [31:0] rdata, status, cause, epc;
   logic        int_req, timer_int;
   logic [31:0] rdata2, status2, cause2, epc2;
   logic        int_req2, timer_int2;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cp0_ctrl #(.CNT_DIV(1), .PRID_VAL(PRID)) dut (
      .clk(clk), .rst(rst), .int_i(int_i),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rdata),
      .exc_valid_i(exc_valid), .exc_code_i(exc_code), .exc_pc_i(exc_pc),
      .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_badvaddr), .eret_i(eret),
      .int_req_o(int_req), .timer_int_o(timer_int),
      .status_o(status), .cause_o(cause), .epc_o(epc)
   );

   cp0_ctrl #(.CNT_DIV(2), .PRID_VAL(PRID)) dut2 (
      .clk(clk), .rst(rst), .int_i(int_i),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rdata2),
      .exc_valid_i(exc_valid), .exc_code_i(exc_code), .exc_pc_i(exc_pc),
      .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_badvaddr), .eret_i(eret),
      .int_req_o(int_req2), .timer_int_o(timer_int2),
      .status_o(status2), .cause_o(cause2), .epc_o(epc2)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] bva;
      logic        er;
      logic [5:0]  irq;
      logic [4:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic we_, input logic [4:0] wa, input logic [31:0] wd,
                               input logic exc, input logic [4:0] code, input logic [31:0] pc,
                               input logic bd, input logic [31:0] bva, input logic er,
                               input logic [5:0] irq, input logic [4:0] ra,
                               input logic [31:0] exp_rd, input logic exp_irq);
      vec_t v;
      v.we = we_; v.wa = wa; v.wd = wd; v.exc = exc; v.code = code; v.pc = pc;
      v.bd = bd; v.bva = bva; v.er = er; v.irq = irq; v.ra = ra;
      v.exp_rd = exp_rd; v.exp_irq = exp_irq;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
      eret = 1'b0; int_i = '0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      //               we   wa     wd            exc  code   pc            bd   bva           er   irq        ra     exp_rd        irq
      vecs[0]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_STS, 32'h1000_0000, 1'b0);
      vecs[1]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_CFG, 32'h0000_8000, 1'b0);
      vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_PRI, PRID,          1'b0);
      vecs[3]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_CAU, 32'h0,         1'b0);
      vecs[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_EPC, 32'h0,         1'b0);
      vecs[5]  = mk(1'b1, R_STS, 32'h0000_8001,1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b100000, R_STS, 32'h0000_8001, 1'b1);
      vecs[6]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b100000, R_CAU, 32'h0000_8000, 1'b1);
      vecs[7]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h100,     1'b1, 32'h3,       1'b0, 6'b100000, R_EPC, 32'h0000_00FC, 1'b0);
      vecs[8]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b100000, R_CAU, 32'h8000_8010, 1'b0);
      vecs[9]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b100000, R_BVA, 32'h0000_0003, 1'b0);
      vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h200,     1'b0, 32'h44,      1'b0, 6'b100000, R_EPC, 32'h0000_00FC, 1'b0);
      vecs[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000001, R_CAU, 32'h8000_0414, 1'b0);
      vecs[12] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_BVA, 32'h0000_0044, 1'b0);
      vecs[13] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h300,     1'b1, 32'h99,      1'b0, 6'b000000, R_BVA, 32'h0000_0044, 1'b0);
      vecs[14] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b1, 6'b000000, R_STS, 32'h0000_8001, 1'b0);
      vecs[15] = mk(1'b1, R_CAU, 32'hFFFF_FFFF,1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_CAU, 32'h80C0_0300, 1'b0);
      vecs[16] = mk(1'b1, R_STS, 32'h0000_0301,1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_STS, 32'h0000_0301, 1'b1);
      vecs[17] = mk(1'b1, R_STS, 32'h0,        1'b1, 5'd8,  32'h400,     1'b0, 32'h0,       1'b1, 6'b000000, R_STS, 32'h0000_0002, 1'b0);
      vecs[18] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_CAU, 32'h00C0_0320, 1'b0);
      vecs[19] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_EPC, 32'h0000_0400, 1'b0);
      vecs[20] = mk(1'b1, R_EPC, 32'h1234_5678,1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b1, 6'b000000, R_EPC, 32'h1234_5678, 1'b0);
      vecs[21] = mk(1'b1, R_PRI, 32'hFFFF_FFFF,1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_PRI, PRID,          1'b0);
      vecs[22] = mk(1'b1, R_CFG, 32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_CFG, 32'h0000_8000, 1'b0);
      vecs[23] = mk(1'b1, R_BVA, 32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, R_BVA, 32'h0000_0044, 1'b0);
      vecs[24] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, 5'd3,  32'h0,         1'b0);
      vecs[25] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 32'h0,       1'b0, 6'b000000, 5'd10, 32'h0,         1'b0);
      vecs[26] = mk(1'b1, R_EPC, 32'h0000_AAAA,1'b1, 5'd12, 32'h500,     1'b0, 32'h0,       1'b0, 6'b000000, R_EPC, 32'h0000_0500, 1'b0);

      // Reset overrides a concurrent exception, eret and write.
      rst = 1'b1; int_i = 6'b111111; raddr = R_STS;
      wr(R_STS, 32'hFFFF_FFFF);
      exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h100; exc_bd = 1'b1;
      exc_badvaddr = 32'h3; eret = 1'b1;
      tick();
      check("rst status", status, 32'h1000_0000);
      check("rst rdata status", rdata, 32'h1000_0000);
      check("rst cause", cause, 32'h0);
      check("rst epc", epc, 32'h0);
      check("rst int_req", 32'(int_req), 32'h0);
      check("rst timer", 32'(timer_int), 32'h0);
      idle();
      tick();
      rst = 1'b0;

      // Same-cycle write is not bypassed to the read port.
      raddr = R_STS;
      wr(R_STS, 32'h0000_0001);
      #1;
      check("no bypass old", rdata, 32'h1000_0000);
      tick();
      idle();
      check("write lands", rdata, 32'h0000_0001);

      // Table-driven register behaviour.
      do_reset();
      for (int i = 0; i < NVEC; i++) begin
         we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
         exc_valid = vecs[i].exc; exc_code = vecs[i].code; exc_pc = vecs[i].pc;
         exc_bd = vecs[i].bd; exc_badvaddr = vecs[i].bva; eret = vecs[i].er;
         int_i = vecs[i].irq; raddr = vecs[i].ra;
         tick();
         check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
         check($sformatf("vec%0d int_req", i), 32'(int_req), 32'(vecs[i].exp_irq));
      end

      // Timer: Compare=20, Count=10 -> interrupt 11 cycles after the Count write.
      do_reset();
      wr(R_CMP, 32'd20);
      tick();
      wr(R_CNT, 32'd10);
      raddr = R_CNT;
      tick();
      idle();
      check("count after write", rdata, 32'd10);
      for (int k = 1; k <= 11; k++) begin
         tick();
         check($sformatf("timer cyc%0d", k), 32'(timer_int), 32'(k == 11));
      end
      tick(); tick(); tick();
      check("timer sticky", 32'(timer_int), 32'h1);
      raddr = R_CAU;
      #1;
      check("cause timer ip", rdata, 32'h0000_8000);
      check("timer int_req masked", 32'(int_req), 32'h0);
      wr(R_CMP, 32'd100);
      tick();
      idle();
      check("timer clr on cmp write", 32'(timer_int), 32'h0);

      // Compare write during the match cycle keeps the interrupt clear.
      wr(R_CMP, 32'd30);
      tick();
      wr(R_CNT, 32'd29);
      tick();
      idle();
      raddr = R_CNT;
      tick();
      check("count at match", rdata, 32'd30);
      wr(R_CMP, 32'd30);
      tick();
      idle();
      check("cmp write in match", 32'(timer_int), 32'h0);
      tick();
      check("no late match", 32'(timer_int), 32'h0);

      // Count wrap with CNT_DIV=2 (dut2) and CNT_DIV=1 (dut), divider restart.
      do_reset();
      wr(R_CNT, 32'hFFFF_FFFF);
      raddr = R_CNT;
      tick();
      idle();
      check("div2 wrap c0", rdata2, 32'hFFFF_FFFF);
      check("div1 wrap c0", rdata, 32'hFFFF_FFFF);
      tick();
      check("div2 wrap c1", rdata2, 32'hFFFF_FFFF);
      check("div1 wrap c1", rdata, 32'h0);
      tick();
      check("div2 wrap c2", rdata2, 32'h0);
      wr(R_CNT, 32'd5);
      tick();
      idle();
      check("div2 restart c0", rdata2, 32'd5);
      tick();
      check("div2 restart c1", rdata2, 32'd5);
      tick();
      check("div2 restart c2", rdata2, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
